// File: rtl/l3_l2_rev_xbar.sv
// ---------------------------------------------------------------------------
// l3_l2_rev_xbar
//   Return-direction link between butterfly levels 3 and 2. Each 16-port
//   section applies a 4x4 transpose: source s = 16k + 4j + i drives
//   destination d = 16k + 4i + j. The transpose is its own inverse, so this
//   link undoes the forward L2->L3 wiring.
//
//   Every path is independent. Each path registers its flits in a 2-entry
//   in-order skid buffer at the destination side. Both the valid and ready
//   outputs are decoded from the buffer state only. As a result there is no
//   combinational path from l2_in_rdy to l3_out_rdy, and none from
//   l3_out_vld to l2_in_vld.
//
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   l3_out_ch   in   [PORTS][CHANNEL_WIDTH] flit from level-3 output s
//   l3_out_vld  in   [PORTS] flit on l3_out_ch[s] is valid
//   l3_out_rdy  out  [PORTS] path from s can accept a flit this cycle
//   l2_in_ch    out  [PORTS][CHANNEL_WIDTH] flit to level-2 input d
//   l2_in_vld   out  [PORTS] l2_in_ch[d] holds a valid flit
//   l2_in_rdy   in   [PORTS] level-2 input d accepts the flit this cycle
// ---------------------------------------------------------------------------
// Per-path buffer state
//   state     | meaning
//   ST_EMPTY  | no flit buffered; vld = 0, rdy = 1
//   ST_ONE    | head holds one flit; vld = 1, rdy = 1
//   ST_FULL   | head and tail both hold flits; vld = 1, rdy = 0
// ---------------------------------------------------------------------------
module l3_l2_rev_xbar #(
   parameter int PORTS         = 64,
   parameter int CHANNEL_WIDTH = 18
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic [PORTS-1:0][CHANNEL_WIDTH-1:0]       l3_out_ch,
   input  logic [PORTS-1:0]                          l3_out_vld,
   output logic [PORTS-1:0]                          l3_out_rdy,
   output logic [PORTS-1:0][CHANNEL_WIDTH-1:0]       l2_in_ch,
   output logic [PORTS-1:0]                          l2_in_vld,
   input  logic [PORTS-1:0]                          l2_in_rdy
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } path_state_e;

   if (PORTS % 16 != 0) begin : g_bad_ports
      $error("l3_l2_rev_xbar: PORTS (%0d) must be a multiple of 16", PORTS);
   end

   for (genvar gd = 0; gd < PORTS; gd++) begin : g_path
      // Destination gd = 16k + 4i + j is fed by source 16k + 4j + i.
      localparam int SRC = (gd / 16) * 16 + (gd % 4) * 4 + (gd / 4) % 4;

      path_state_e              state_q, state_d;
      logic [CHANNEL_WIDTH-1:0] head_q, head_d;
      logic [CHANNEL_WIDTH-1:0] tail_q, tail_d;
      logic                     vld;
      logic                     rdy;
      logic                     push;
      logic                     pop;

      assign vld  = (state_q != ST_EMPTY);
      assign rdy  = (state_q != ST_FULL);
      assign push = l3_out_vld[SRC] & rdy;
      assign pop  = vld & l2_in_rdy[gd];

      always_comb begin
         state_d = state_q;
         head_d  = head_q;
         tail_d  = tail_q;
         unique case (state_q)
            ST_EMPTY: begin
               if (push) begin
                  head_d  = l3_out_ch[SRC];
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               // A push that coincides with a pop refills the head in place,
               // so streaming runs at one flit per cycle with no bubble.
               if (push && pop) begin
                  head_d = l3_out_ch[SRC];
               end else if (push) begin
                  tail_d  = l3_out_ch[SRC];
                  state_d = ST_FULL;
               end else if (pop) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (pop) begin
                  head_d  = tail_q;
                  state_d = ST_ONE;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
         end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
         end
      end

      assign l2_in_vld[gd]   = vld;
      assign l2_in_ch[gd]    = head_q;
      assign l3_out_rdy[SRC] = rdy;
   end

endmodule

// File: tb/tb_l3_l2_rev_xbar.sv
module tb_l3_l2_rev_xbar;

   localparam int P  = 64;
   localparam int CW = 18;

   typedef logic [CW-1:0] flit_t;

   logic                  clk;
   logic                  rst_n;
   logic [P-1:0][CW-1:0]  drv_ch;
   logic [P-1:0]          drv_vld;
   logic [P-1:0]          l3_out_rdy;
   logic [P-1:0][CW-1:0]  l2_in_ch;
   logic [P-1:0]          l2_in_vld;
   logic [P-1:0]          drv_rdy;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model: one FIFO of flits per destination
   flit_t mq[P][$];
   flit_t last_head[P];

   l3_l2_rev_xbar #(.PORTS(P), .CHANNEL_WIDTH(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .l3_out_ch  (drv_ch),
      .l3_out_vld (drv_vld),
      .l3_out_rdy (l3_out_rdy),
      .l2_in_ch   (l2_in_ch),
      .l2_in_vld  (l2_in_vld),
      .l2_in_rdy  (drv_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int dest_of(int s);
      int k, i, j;
      k = s / 16;
      i = s % 4;
      j = (s / 4) % 4;
      return 16 * k + 4 * i + j;
   endfunction

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < P; d++) begin
         mq[d].delete();
         last_head[d] = '0;
      end
   endtask

   task automatic check_outputs();
      logic [P-1:0] exp_vld;
      logic [P-1:0] exp_rdy;
      flit_t        exp_ch;
      for (int d = 0; d < P; d++) exp_vld[d] = (mq[d].size() > 0);
      for (int s = 0; s < P; s++) exp_rdy[s] = (mq[dest_of(s)].size() < 2);
      chk("l2_in_vld", 64'(l2_in_vld), 64'(exp_vld));
      chk("l3_out_rdy", 64'(l3_out_rdy), 64'(exp_rdy));
      for (int d = 0; d < P; d++) begin
         exp_ch = (mq[d].size() > 0) ? mq[d][0] : last_head[d];
         chk("l2_in_ch", 64'(l2_in_ch[d]), 64'(exp_ch));
      end
   endtask

   task automatic model_update();
      bit do_pop[P];
      bit do_push[P];
      for (int d = 0; d < P; d++) begin
         do_pop[d]  = (mq[d].size() > 0) && drv_rdy[d];
         do_push[d] = 1'b0;
      end
      for (int s = 0; s < P; s++) begin
         int d;
         d = dest_of(s);
         if (drv_vld[s] && mq[d].size() < 2) do_push[d] = 1'b1;
      end
      for (int s = 0; s < P; s++) begin
         int   d;
         flit_t f;
         d = dest_of(s);
         if (do_pop[d]) begin
            f = mq[d].pop_front();
            do_pop[d] = 1'b0;
         end
         if (do_push[d]) mq[d].push_back(drv_ch[s]);
         if (mq[d].size() > 0) last_head[d] = mq[d][0];
      end
   endtask

   // check current outputs, account for this edge in the model, advance
   task automatic step();
      check_outputs();
      model_update();
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_vld"}, 64'(l2_in_vld), 64'd0);
      chk({tag, "_rdy"}, 64'(l3_out_rdy), {64{1'b1}});
      for (int d = 0; d < P; d++) chk({tag, "_ch"}, 64'(l2_in_ch[d]), 64'd0);
   endtask

   initial begin
      rst_n   = 1'b0;
      drv_ch  = '0;
      drv_vld = '0;
      drv_rdy = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // mapping sweep: one flit per source, sink always ready
      drv_rdy = '1;
      for (int s = 0; s < P; s++) begin
         drv_vld    = '0;
         drv_vld[s] = 1'b1;
         drv_ch[s]  = flit_t'(18'h3F000 + s);
         step();
         chk("map_vld", 64'(l2_in_vld), 64'd1 << dest_of(s));
         chk("map_ch", 64'(l2_in_ch[dest_of(s)]), 64'(18'h3F000 + s));
      end
      drv_vld = '0;
      step();

      // streaming s=1 -> d=4
      for (int k = 1; k <= 16; k++) begin
         drv_vld    = '0;
         drv_vld[1] = 1'b1;
         drv_ch[1]  = flit_t'(k);
         step();
         chk("stream_ch", 64'(l2_in_ch[4]), 64'(k));
         chk("stream_vld", 64'(l2_in_vld[4]), 64'd1);
         chk("stream_rdy", 64'(l3_out_rdy[1]), 64'd1);
      end
      drv_vld = '0;
      step();

      // backpressure: fill path 1->4, then drain
      drv_rdy[4] = 1'b0;
      drv_vld[1] = 1'b1;
      drv_ch[1]  = 18'h0AAAA;
      step();
      drv_ch[1]  = 18'h0BBBB;
      step();
      drv_vld[1] = 1'b0;
      chk("bp_full_rdy", 64'(l3_out_rdy[1]), 64'd0);
      chk("bp_head_a", 64'(l2_in_ch[4]), 64'h0AAAA);
      chk("bp_vld", 64'(l2_in_vld[4]), 64'd1);
      step();
      chk("bp_hold_a", 64'(l2_in_ch[4]), 64'h0AAAA);
      chk("bp_hold_rdy", 64'(l3_out_rdy[1]), 64'd0);
      drv_rdy[4] = 1'b1;
      step();
      chk("bp_head_b", 64'(l2_in_ch[4]), 64'h0BBBB);
      chk("bp_rdy_back", 64'(l3_out_rdy[1]), 64'd1);
      chk("bp_vld_b", 64'(l2_in_vld[4]), 64'd1);
      step();
      chk("bp_empty", 64'(l2_in_vld[4]), 64'd0);
      chk("bp_ch_held", 64'(l2_in_ch[4]), 64'h0BBBB);

      // simultaneous push/pop in ONE
      drv_vld[1] = 1'b1;
      drv_ch[1]  = 18'h0A5A5;
      step();
      chk("pp_head_a", 64'(l2_in_ch[4]), 64'h0A5A5);
      drv_ch[1]  = 18'h0C3C3;
      step();
      chk("pp_head_c", 64'(l2_in_ch[4]), 64'h0C3C3);
      chk("pp_vld", 64'(l2_in_vld[4]), 64'd1);
      chk("pp_rdy", 64'(l3_out_rdy[1]), 64'd1);
      drv_vld[1] = 1'b0;
      step();
      chk("pp_drained", 64'(l2_in_vld[4]), 64'd0);

      // random traffic on all paths, with a reset in the middle
      for (int cyc = 0; cyc < 10000; cyc++) begin
         int vd, rd;
         vd = (cyc / 1000) % 4;
         rd = (cyc / 700) % 4;
         for (int s = 0; s < P; s++) begin
            drv_vld[s] = ($urandom_range(0, 3) <= vd);
            drv_rdy[s] = ($urandom_range(0, 3) <= rd);
            drv_ch[s]  = flit_t'($urandom);
         end
         if (cyc == 5000) begin
            #2 rst_n = 1'b0;
            #1 check_reset_outputs("mid_reset");
            @(negedge clk);
            check_reset_outputs("reset_hold");
            @(negedge clk);
            rst_n = 1'b1;
            model_reset();
         end
         step();
      end

      drv_vld = '0;
      drv_rdy = '1;
      repeat (3) step();
      check_outputs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
